mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DEPTH_WORDS, default 128, SHALL set the number of 32-bit words in the attached data memory.
REQ-002 CLK  in  1  SHALL be the sole clock; all state changes on its rising edge.
REQ-003 RESET  in  1  SHALL be an asynchronous, active-low reset.
REQ-004 Req  in  1  SHALL request an access; sampled only in IDLE.
REQ-005 IsStore  in  1  SHALL select store (1) or load (0).
REQ-006 Size  in  2  SHALL encode the access size: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-007 Signed  in  1  SHALL select sign-extension (1) or zero-extension (0) on sub-word loads.
REQ-008 Addr  in  32  SHALL carry the byte address.
REQ-009 WriteData  in  32  SHALL carry store data, right-aligned for sub-word stores.
REQ-010 Busy  out  1  SHALL be high in every state except IDLE.
REQ-011 Done  out  1  SHALL pulse high for exactly one cycle when an access completes.
REQ-012 Fault  out  1  SHALL be high together with Done when the access was rejected.
REQ-013 LoadData  out  32  SHALL carry the extracted and extended load result.
REQ-014 MemAddress  out  32  SHALL carry the word index (Addr[31:2]) to the data memory.
REQ-015 MemWE  out  1  SHALL be the data memory write enable.
REQ-016 MemWD  out  32  SHALL be the data memory write data.
REQ-017 MemRD  in  32  SHALL be the combinational read data returned for MemAddress.

Function
REQ-018 FSM states SHALL be IDLE, READ, WRITE and DONE.
REQ-019 IDLE with Req=1 SHALL latch IsStore, Size, Signed, Addr and WriteData, then classify the access:
- fault -> DONE with Fault=1;
- word store -> WRITE;
- any other access -> READ.
REQ-020 Fault conditions SHALL be:
- Size=11;
- halfword access with Addr[0]=1;
- word access with Addr[1:0]!=00;
- Addr[31:2] >= DEPTH_WORDS.
REQ-021 READ SHALL capture MemRD; a load then goes to DONE, a sub-word store goes to WRITE.
REQ-022 Sub-word store merge SHALL replace only the addressed lane(s) of the captured word with WriteData[7:0] or WriteData[15:0]; all other bits are kept.
REQ-023 Byte lanes SHALL be little-endian: byte k occupies bits [8k+7:8k].
REQ-024 WRITE SHALL assert MemWE=1 for exactly one cycle, with MemWD equal to the merged word or WriteData, then go to DONE.
REQ-025 DONE SHALL assert Done=1 and return to IDLE; a Req present in DONE SHALL be ignored.
REQ-026 Latency, counting T as the accept cycle in IDLE, SHALL be:
- load and word store: Done at T+2;
- sub-word store: Done at T+3;
- fault: Done at T+1.
REQ-027 MemWE SHALL be 0 outside WRITE; a faulted access SHALL never assert MemWE.
REQ-028 MemAddress SHALL hold the latched word index while Busy=1 and SHALL be 0 in IDLE.
REQ-029 LoadData SHALL update only on successful load completion and otherwise hold its value; stores and faults SHALL leave it unchanged.

Reset
REQ-030 RESET=0 SHALL immediately force:
- state IDLE;
- Busy=0, Done=0, Fault=0, MemWE=0;
- MemAddress, MemWD and LoadData to 0.
REQ-031 A reset asserted mid-access SHALL abort it; no partial or subsequent write is committed and no Done is issued.

Configuration
REQ-032 With macro MEM_HALFWORD_EN defined, Size=01 SHALL perform halfword loads and stores on lanes [15:0] or [31:16], selected by Addr[1].
REQ-033 Without MEM_HALFWORD_EN, Size=01 SHALL be treated as reserved and fault per REQ-020.

Verification
All scenarios use memory preload word0=0x00000000, word1=0x00000002, word2=0xFFFFFFFE.
REQ-034 Word load Addr=0x8 -> Done at T+2, LoadData=0xFFFFFFFE, Fault=0, MemWE never 1.
REQ-035 Byte load Addr=0x9 -> LoadData=0xFFFFFFFF with Signed=1; LoadData=0x000000FF with Signed=0.
REQ-036 Byte store Addr=0x5, WriteData=0x123456AB -> MemWE=1 at T+2 with MemWD=0x0000AB02 and MemAddress=1; Done at T+3.
REQ-037 Word load Addr=0x6, then word store Addr=0x200 -> each gives Done=Fault=1 at T+1, MemWE stays 0, LoadData unchanged.
REQ-038 Reset pulse during WRITE of a byte store to Addr=0x4 -> MemWE drops asynchronously, word1 stays 0x00000002, FSM in IDLE, no Done.
REQ-039 Halfword load Addr=0xA, Signed=1 -> LoadData=0xFFFFFFFF at T+2 with MEM_HALFWORD_EN; Fault=1 at T+1 without it.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit: sub-word extraction, read-modify-write sub-word stores, alignment and range faults.
// Defining MEM_HALFWORD_EN enables halfword (Size=01) accesses. Without it, Size=01 faults like a reserved size.
module mem_access_unit #(
  parameter int unsigned DEPTH_WORDS = 128
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Req,
  input  logic        IsStore,
  input  logic [1:0]  Size,
  input  logic        Signed,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic        Busy,
  output logic        Done,
  output logic        Fault,
  output logic [31:0] LoadData,
  output logic [31:0] MemAddress,
  output logic        MemWE,
  output logic [31:0] MemWD,
  input  logic [31:0] MemRD
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state, state_nxt;
  logic        is_store_q, signed_q, fault_q, bad;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, word_q, merged, extended;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    bad = 1'b0;
    unique case (Size)
      2'b00: bad = 1'b0;
`ifdef MEM_HALFWORD_EN
      2'b01: bad = Addr[0];
`else
      2'b01: bad = 1'b1;
`endif
      2'b10: bad = |Addr[1:0];
      default: bad = 1'b1;
    endcase
    if ({2'b00, Addr[31:2]} >= 32'(DEPTH_WORDS)) bad = 1'b1;
  end

  // Lane select and merge both work on the word returned in READ.
  always_comb begin
    byte_v = MemRD[{addr_q[1:0], 3'b000} +: 8];
    half_v = MemRD[{addr_q[1], 4'b0000} +: 16];
    merged = MemRD;
    if (size_q == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
    else                 merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    unique case (size_q)
      2'b00:   extended = signed_q ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
      2'b01:   extended = signed_q ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
      default: extended = MemRD;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    Busy       = (state != IDLE);
    Done       = (state == DONE);
    Fault      = (state == DONE) && fault_q;
    MemWE      = (state == WRITE);
    MemWD      = (state == WRITE) ? word_q : '0;
    MemAddress = (state != IDLE) ? {2'b00, addr_q[31:2]} : '0;
    unique case (state)
      IDLE: if (Req) begin
        if (bad)                          state_nxt = DONE;
        else if (IsStore && Size == 2'b10) state_nxt = WRITE;
        else                              state_nxt = READ;
      end
      READ:    state_nxt = is_store_q ? WRITE : DONE;
      WRITE:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      is_store_q <= 1'b0;
      signed_q   <= 1'b0;
      fault_q    <= 1'b0;
      size_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      word_q     <= '0;
      LoadData   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && Req) begin
        is_store_q <= IsStore;
        signed_q   <= Signed;
        size_q     <= Size;
        addr_q     <= Addr;
        wdata_q    <= WriteData;
        fault_q    <= bad;
        word_q     <= WriteData;
      end
      if (state == READ) begin
        if (is_store_q) word_q   <= merged;
        else            LoadData <= extended;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random accesses against a lane/mask model.
module tb_mem_access_unit;

`ifdef MEM_HALFWORD_EN
  localparam bit HW = 1'b1;
`else
  localparam bit HW = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        Req = 1'b0, IsStore = 1'b0, Signed = 1'b0;
  logic [1:0]  Size = 2'b00;
  logic [31:0] Addr = '0, WriteData = '0;
  logic        Busy, Done, Fault, MemWE;
  logic [31:0] LoadData, MemAddress, MemWD, MemRD;

  logic [31:0] mem     [128];
  logic [31:0] ref_mem [128];
  logic [31:0] exp_load = '0;
  int unsigned n_checks = 0, n_fail = 0;

  mem_access_unit #(.DEPTH_WORDS(128)) dut (
    .CLK(CLK), .RESET(RESET), .Req(Req), .IsStore(IsStore), .Size(Size),
    .Signed(Signed), .Addr(Addr), .WriteData(WriteData), .Busy(Busy),
    .Done(Done), .Fault(Fault), .LoadData(LoadData), .MemAddress(MemAddress),
    .MemWE(MemWE), .MemWD(MemWD), .MemRD(MemRD)
  );

  always #5 CLK = ~CLK;

  always_comb MemRD = (MemAddress < 32'd128) ? mem[MemAddress[6:0]] : '0;
  always @(posedge CLK) if (MemWE && MemAddress < 32'd128) mem[MemAddress[6:0]] <= MemWD;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic run_access(input bit st, input logic [1:0] sz, input bit sg,
                            input logic [31:0] ad, input logic [31:0] wd);
    logic [31:0] idx, off, w, v, mask, exp_wd;
    bit          exp_fault, exp_we;
    int unsigned lat, got_done, we_cnt, we_cycle;
    logic [31:0] got_fault, we_wd, we_addr, ld_at_done;

    idx = ad >> 2;
    off = ad & 32'd3;
    exp_fault = (sz == 2'd3) || (sz == 2'd1 && (!HW || ad[0])) ||
                (sz == 2'd2 && off != 0) || (idx >= 128);
    lat = exp_fault ? 1 : ((st && sz != 2'd2) ? 3 : 2);
    exp_we = st && !exp_fault;
    exp_wd = '0;
    if (!exp_fault) begin
      w = ref_mem[idx[6:0]];
      if (!st) begin
        if (sz == 2'd0) begin
          v = (w >> (8 * off)) & 32'hFF;
          if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
          v = (w >> (8 * off)) & 32'hFFFF;
          if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else v = w;
        exp_load = v;
      end else begin
        mask = (sz == 2'd0) ? (32'hFF << (8 * off)) :
               (sz == 2'd1) ? (32'hFFFF << (8 * off)) : 32'hFFFF_FFFF;
        exp_wd = (w & ~mask) | ((wd << (8 * off)) & mask);
        ref_mem[idx[6:0]] = exp_wd;
      end
    end

    @(negedge CLK);
    Req = 1'b1; IsStore = st; Size = sz; Signed = sg; Addr = ad; WriteData = wd;
    got_done = 0; got_fault = '0; we_cnt = 0; we_cycle = 0;
    we_wd = '0; we_addr = '0; ld_at_done = '0;
    for (int unsigned k = 1; k <= 6; k++) begin
      @(negedge CLK);
      if (k == 1) check("busy_t1", {31'b0, Busy}, 32'd1);
      if (MemWE) begin
        we_cnt++; we_cycle = k; we_wd = MemWD; we_addr = MemAddress;
      end
      if (Done) begin
        got_done = k; got_fault = {31'b0, Fault}; ld_at_done = LoadData;
        break;
      end
    end
    check("done_cycle", got_done, lat);
    check("fault", got_fault, {31'b0, exp_fault});
    check("we_count", we_cnt, {31'b0, exp_we});
    if (exp_we) begin
      check("we_cycle", we_cycle, lat - 1);
      check("mem_wd", we_wd, exp_wd);
      check("mem_addr", we_addr, idx);
    end
    check("load_data", ld_at_done, exp_load);
    // Req is still high across the DONE edge; it must not start a new access.
    @(negedge CLK);
    check("busy_after", {31'b0, Busy}, 32'd0);
    check("addr_idle", MemAddress, 32'd0);
    Req = 1'b0;
    if (idx < 128) check("mem_word", mem[idx[6:0]], ref_mem[idx[6:0]]);
  endtask

  task automatic reset_mid_write();
    int unsigned dones;
    @(negedge CLK);
    Req = 1'b1; IsStore = 1'b1; Size = 2'b00; Signed = 1'b0; Addr = 32'h4; WriteData = 32'hDEAD_BEEF;
    @(negedge CLK);
    Req = 1'b0;
    @(negedge CLK);
    check("rst_we_before", {31'b0, MemWE}, 32'd1);
    #1 RESET = 1'b0;
    #1;
    check("rst_we_async", {31'b0, MemWE}, 32'd0);
    check("rst_busy", {31'b0, Busy}, 32'd0);
    check("rst_load", LoadData, 32'd0);
    exp_load = '0;
    @(negedge CLK);
    RESET = 1'b1;
    dones = 0;
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge CLK);
      if (Done) dones++;
    end
    check("rst_no_done", dones, 32'd0);
    check("rst_word1", mem[1], 32'h0000_0002);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[0] = 32'h0; mem[1] = 32'h2; mem[2] = 32'hFFFF_FFFE;
    ref_mem[0] = 32'h0; ref_mem[1] = 32'h2; ref_mem[2] = 32'hFFFF_FFFE;

    #2;
    check("rst_busy0", {31'b0, Busy}, 32'd0);
    check("rst_done0", {31'b0, Done}, 32'd0);
    check("rst_fault0", {31'b0, Fault}, 32'd0);
    check("rst_we0", {31'b0, MemWE}, 32'd0);
    check("rst_maddr0", MemAddress, 32'd0);
    check("rst_mwd0", MemWD, 32'd0);
    check("rst_ld0", LoadData, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;

    run_access(1'b0, 2'b10, 1'b0, 32'h8, '0);
    check("word_load_val", LoadData, 32'hFFFF_FFFE);
    run_access(1'b0, 2'b00, 1'b1, 32'h9, '0);
    check("byte_ld_signed", LoadData, 32'hFFFF_FFFF);
    run_access(1'b0, 2'b00, 1'b0, 32'h9, '0);
    check("byte_ld_unsigned", LoadData, 32'h0000_00FF);
    reset_mid_write();
    run_access(1'b1, 2'b00, 1'b0, 32'h5, 32'h1234_56AB);
    check("byte_store_word1", mem[1], 32'h0000_AB02);
    run_access(1'b0, 2'b10, 1'b0, 32'h6, '0);
    run_access(1'b1, 2'b10, 1'b0, 32'h200, 32'hCAFE_F00D);
    run_access(1'b0, 2'b01, 1'b1, 32'hA, '0);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = (($urandom % 16) == 0) ? $urandom : 32'($urandom_range(0, 540));
      run_access(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no end of stimulus, expected completion");
    $fatal(1);
  end

endmodule
